// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator datapath types and defaults
package calc_pkg;

    localparam int DEFAULT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } calc_state_e;

endpackage

// File: rtl/inv_fact_step.sv
// rtl/inv_fact_step.sv - one multiply-compare step of the inverse factorial search
module inv_fact_step
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]   n,
    input  logic [WIDTH-1:0]   t,
    output logic [2*WIDTH-1:0] next_acc,
    output logic               advance
);

    logic [2*WIDTH-1:0] acc_w;
    logic [2*WIDTH-1:0] mult_w;
    logic [2*WIDTH-1:0] t_w;

    // acc never exceeds t, so acc*(n+1) always fits in 2*WIDTH bits
    assign acc_w    = {{WIDTH{1'b0}}, acc};
    assign mult_w   = {{WIDTH{1'b0}}, n} + {{(2*WIDTH-1){1'b0}}, 1'b1};
    assign t_w      = {{WIDTH{1'b0}}, t};
    assign next_acc = acc_w * mult_w;
    assign advance  = (next_acc <= t_w);

endmodule

// File: rtl/six_bit_inverse_factorial.sv
// rtl/six_bit_inverse_factorial.sv - iterative largest-n search with n! <= target
module six_bit_inverse_factorial
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             invalid
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    calc_state_e        state_q;
    calc_state_e        state_d;
    logic [WIDTH-1:0]   t_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   n_q;
    logic [2*WIDTH-1:0] next_acc;
    logic               advance;

    inv_fact_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_q),
        .n        (n_q),
        .t        (t_q),
        .next_acc (next_acc),
        .advance  (advance)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (target == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (!advance) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            acc_q   <= ONE;
            n_q     <= ONE;
            result  <= '0;
            exact   <= 1'b0;
            invalid <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        t_q     <= target;
                        acc_q   <= ONE;
                        n_q     <= ONE;
                        result  <= '0;
                        exact   <= 1'b0;
                        invalid <= (target == '0);
                    end
                end
                CALC: begin
                    if (advance) begin
                        acc_q <= next_acc[WIDTH-1:0];
                        n_q   <= n_q + ONE;
                    end else begin
                        result  <= n_q;
                        exact   <= (acc_q == t_q);
                        invalid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_six_bit_inverse_factorial.sv
// tb/tb_six_bit_inverse_factorial.sv - directed self-checking bench for six_bit_inverse_factorial
module tb_six_bit_inverse_factorial;

    logic       clk;
    logic       rst;
    logic       start;
    logic [5:0] target;
    logic       busy;
    logic       done;
    logic [5:0] result;
    logic       exact;
    logic       invalid;

    int compared;
    int mismatched;

    six_bit_inverse_factorial dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .target  (target),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .exact   (exact),
        .invalid (invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fact(input int k);
        int f;
        f = 1;
        for (int i = 2; i <= k; i++) f = f * i;
        return f;
    endfunction

    // Starts at a negedge with the DUT idle; returns at the negedge after done.
    task automatic do_run(input logic [5:0] t, output logic [5:0] r, output logic ex,
                          output logic inv, output int calc, output bit to);
        start  = 1'b1;
        target = t;
        @(negedge clk);
        start  = 1'b0;
        calc   = 0;
        to     = 1'b1;
        r      = '0;
        ex     = 1'b0;
        inv    = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                to  = 1'b0;
                r   = result;
                ex  = exact;
                inv = invalid;
                break;
            end
            if (busy) calc++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        target = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        compared++;
        if ({busy, done, result, exact, invalid} !== 10'b0) begin
            mismatched++;
            $display("FAIL reset_initial: got busy=%b done=%b result=%0d exact=%b invalid=%b, want all 0",
                     busy, done, result, exact, invalid);
        end
        // reset mid-CALC with T=63
        start = 1'b1;
        target = 6'd63;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_precond_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({busy, done, result, exact, invalid} !== 10'b0) begin
            mismatched++;
            $display("FAIL reset_midcalc: got busy=%b done=%b result=%0d exact=%b invalid=%b, want all 0",
                     busy, done, result, exact, invalid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            compared++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_no_done: cycle %0d got busy=%b done=%b want 0 0", i, busy, done);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero();
        logic [5:0] r;
        logic ex, inv;
        int calc;
        bit to;
        do_run(6'd0, r, ex, inv, calc, to);
        compared++;
        if (to || r !== 6'd0 || ex !== 1'b0 || inv !== 1'b1 || calc !== 0) begin
            mismatched++;
            $display("FAIL zero_target: got timeout=%b result=%0d exact=%b invalid=%b calc=%0d, want 0 0 0 1 0",
                     to, r, ex, inv, calc);
        end
    endtask

    task automatic test_vectors();
        logic [5:0] tv [7] = '{6'd1, 6'd2, 6'd6, 6'd24, 6'd5, 6'd23, 6'd63};
        logic [5:0] rv [7] = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd2, 6'd3, 6'd4};
        logic       ev [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [5:0] r;
        logic ex, inv;
        int calc;
        bit to;
        for (int k = 0; k < 7; k++) begin
            do_run(tv[k], r, ex, inv, calc, to);
            compared++;
            if (to || r !== rv[k] || ex !== ev[k] || inv !== 1'b0 || calc !== int'(rv[k])) begin
                mismatched++;
                $display("FAIL vector_T%0d: got timeout=%b result=%0d exact=%b invalid=%b calc=%0d, want result=%0d exact=%b invalid=0 calc=%0d",
                         tv[k], to, r, ex, inv, calc, rv[k], ev[k], rv[k]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        bit seen;
        start = 1'b1;
        target = 6'd63;
        @(negedge clk);
        target = 6'd5;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (!seen || result !== 6'd4 || exact !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_ignore_first: got seen=%b result=%0d exact=%b, want 1 4 0", seen, result, exact);
        end
        @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_ignore_in_done: got busy=%b want 0", busy);
        end
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL busy_ignore_next_accept: got busy=%b want 1", busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (!seen || result !== 6'd2 || exact !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_ignore_second: got seen=%b result=%0d exact=%b, want 1 2 0", seen, result, exact);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [5:0] r;
        logic ex, inv;
        int calc;
        bit to;
        int fr, fr1;
        for (int t = 0; t < 64; t++) begin
            do_run(6'(t), r, ex, inv, calc, to);
            repeat (25 - calc - 2) @(negedge clk);
            fr  = fact(int'(r));
            fr1 = fact(int'(r) + 1);
            compared++;
            if (to) begin
                mismatched++;
                $display("FAIL sweep_timeout_T%0d: got no done within 20 cycles, want done", t);
            end else if (t == 0) begin
                if (inv !== 1'b1 || r !== 6'd0 || ex !== 1'b0) begin
                    mismatched++;
                    $display("FAIL sweep_T0: got result=%0d exact=%b invalid=%b, want 0 0 1", r, ex, inv);
                end
            end else if (inv !== 1'b0 || fr > t || fr1 <= t || ex !== (fr == t)) begin
                mismatched++;
                $display("FAIL sweep_T%0d: got result=%0d exact=%b invalid=%b, want fact(r)<=T<fact(r+1) exact=%b invalid=0",
                         t, r, ex, inv, (fr == t));
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst    = 1'b1;
        start  = 1'b0;
        target = '0;
        @(negedge clk);
        test_reset();
        test_zero();
        test_vectors();
        test_busy_ignore();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
